// File: rtl/ipfu_pkg.sv
// ipfu_pkg: shared types and constants for the instruction prefetch unit.
//   - AXI4 read-channel encodings used by the fetch master.
//   - FSM state enumeration.
//   - Prefetch FIFO entry layout (pc, instruction word, bus-fault flag).
package ipfu_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // The entry pc field is sized for the widest supported fetch address;
  // narrower instances zero-extend on push and truncate on read.
  localparam int IPFU_PC_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN
  } ipfu_state_t;

  typedef struct packed {
    logic [IPFU_PC_W-1:0] pc;
    logic [31:0]          instr;
    logic                 fault;
  } ipfu_entry_t;

endpackage

// File: rtl/instr_prefetch_unit_prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of ipfu_entry_t with a show-ahead head.
//   clk, srst   : clock, synchronous active-high reset
//   flush       : empties the FIFO this cycle (wins over push/pop)
//   push, push_data : write one entry
//   pop         : consume the head; ignored when empty
//   head_data, head_valid : current head entry and its valid flag
//   count       : number of stored entries (log2(DEPTH)+1 bits)
module prefetch_fifo
  import ipfu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     flush,
  input  logic                     push,
  input  ipfu_entry_t              push_data,
  input  logic                     pop,
  output ipfu_entry_t              head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ipfu_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  assign pop_ok     = pop && (count_reg != '0);
  assign head_valid = (count_reg != '0);
  assign head_data  = mem[rd_ptr_reg];
  assign count      = count_reg;

  // Storage carries no reset so it maps onto plain distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // The fetch FSM reserves space before issuing a burst, so a push into a
  // full FIFO would indicate a reservation bug.
  assert property (@(posedge clk) disable iff (srst || flush)
    !(push && !pop_ok && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: autonomous AXI4 INCR-burst instruction prefetcher.
//   clk, reset                     : clock, synchronous active-high reset
//   fetch_enable                   : allows new bursts to be issued
//   redirect_valid, redirect_pc    : flush and restart fetching at redirect_pc
//   instr_valid/instr_ready        : head-of-FIFO handshake towards the core
//   instruction, instr_pc, instr_fault : head entry contents
//   m_axi_ar*                      : AXI4 read-address channel (master)
//   m_axi_r*                       : AXI4 read-data channel (master)
module instr_prefetch_unit
  import ipfu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 8,
  parameter int                BURST_LEN  = 4,
  parameter logic [3:0]        AXI_ID     = 4'd0,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_fault,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [1:0]        m_axi_arburst,
  output logic [3:0]        m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [3:0]        m_axi_rid,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [12:0] BURST_BEATS = 13'(BURST_LEN);

  ipfu_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] target_reg, target_next;
  logic              flush_pending_reg, flush_pending_next;
  logic              halted_reg, halted_next;
  logic [ADDR_W-1:0] araddr_reg, araddr_next;
  logic [7:0]        arlen_reg, arlen_next;

  logic              push;
  ipfu_entry_t       push_entry;
  ipfu_entry_t       head_entry;
  logic              head_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic              beat_accept;
  logic [ADDR_W-1:0] redirect_target;
  logic [12:0]       page_words;
  logic [12:0]       beats;
  logic [12:0]       free_slots;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pop             = head_valid && instr_ready;
  assign m_axi_rready    = (state_reg == DATA) || (state_reg == DRAIN);
  assign beat_accept     = m_axi_rvalid && m_axi_rready;

  // Words left before the next 4 KB page; a burst never crosses it.
  assign page_words = (13'h1000 - {1'b0, fetch_pc_reg[11:0]}) >> 2;
  assign beats      = (page_words < BURST_BEATS) ? page_words : BURST_BEATS;
  // A pop in the same cycle already frees its slot for the reservation.
  assign free_slots = 13'(FIFO_DEPTH) - 13'(fifo_count) + 13'(pop);

  always_comb begin
    state_next         = state_reg;
    fetch_pc_next      = fetch_pc_reg;
    target_next        = target_reg;
    flush_pending_next = flush_pending_reg;
    halted_next        = halted_reg;
    araddr_next        = araddr_reg;
    arlen_next         = arlen_reg;
    push               = 1'b0;
    push_entry         = '0;
    push_entry.pc[ADDR_W-1:0] = fetch_pc_reg;
    push_entry.instr   = m_axi_rdata;
    push_entry.fault   = (m_axi_rresp != RESP_OKAY);

    if (redirect_valid) begin
      target_next = redirect_target;
      halted_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_target;
        end else if (fetch_enable && !halted_reg && (free_slots >= beats)) begin
          state_next  = REQ;
          araddr_next = fetch_pc_reg;
          arlen_next  = 8'(beats - 13'd1);
        end
      end
      REQ: begin
        // The address phase cannot be withdrawn; a redirect here only
        // marks the burst for discarding once it is accepted.
        if (redirect_valid) begin
          flush_pending_next = 1'b1;
        end
        if (m_axi_arready) begin
          state_next         = (flush_pending_reg || redirect_valid) ? DRAIN : DATA;
          flush_pending_next = 1'b0;
        end
      end
      DATA: begin
        if (redirect_valid) begin
          // Beat arriving with the redirect is dropped along with the flush.
          if (beat_accept && m_axi_rlast) begin
            state_next    = IDLE;
            fetch_pc_next = redirect_target;
          end else begin
            state_next = DRAIN;
          end
        end else if (beat_accept) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
          if (m_axi_rresp != RESP_OKAY) begin
            halted_next = 1'b1;
          end
          if (m_axi_rlast) begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        if (beat_accept && m_axi_rlast) begin
          state_next    = IDLE;
          fetch_pc_next = redirect_valid ? redirect_target : target_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      fetch_pc_reg      <= RESET_PC;
      target_reg        <= RESET_PC;
      flush_pending_reg <= 1'b0;
      halted_reg        <= 1'b0;
      araddr_reg        <= '0;
      arlen_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      fetch_pc_reg      <= fetch_pc_next;
      target_reg        <= target_next;
      flush_pending_reg <= flush_pending_next;
      halted_reg        <= halted_next;
      araddr_reg        <= araddr_next;
      arlen_reg         <= arlen_next;
    end
  end

  prefetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .head_valid(head_valid),
    .count     (fifo_count)
  );

  // Head fields are gated so uninitialised RAM never reaches the outputs.
  assign instr_valid = head_valid;
  assign instruction = head_valid ? head_entry.instr : '0;
  assign instr_pc    = head_valid ? head_entry.pc[ADDR_W-1:0] : '0;
  assign instr_fault = head_valid && head_entry.fault;

  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arlen   = arlen_reg;
  assign m_axi_arvalid = (state_reg == REQ);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arid    = AXI_ID;

  logic unused_bits;
  assign unused_bits = ^{m_axi_rid, redirect_pc[1:0], head_entry.pc};

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  instr_prefetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_enable  (fetch_enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .instr_fault   (instr_fault),
    .m_axi_araddr  (araddr),
    .m_axi_arburst (arburst),
    .m_axi_arid    (arid),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rid     (rid),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  // ---------------- AXI read slave: data = address, zero wait ----------------
  logic        ar_ready_en = 1'b1;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = '0;
  logic        s_busy;
  logic [31:0] s_addr;
  logic [7:0]  s_left;

  assign arready = ar_ready_en && !s_busy;
  assign rid     = 4'h0;

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return (fault_en && (a == fault_addr)) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      s_busy <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      rdata <= '0; rresp <= '0; s_addr <= '0; s_left <= '0;
    end else if (!s_busy) begin
      if (arvalid && arready) begin
        s_busy <= 1'b1; rvalid <= 1'b1;
        s_addr <= araddr; rdata <= araddr; rresp <= resp_for(araddr);
        rlast  <= (arlen == 8'd0); s_left <= arlen;
      end
    end else if (rvalid && rready) begin
      if (rlast) begin
        s_busy <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      end else begin
        s_addr <= s_addr + 32'd4; rdata <= s_addr + 32'd4;
        rresp  <= resp_for(s_addr + 32'd4);
        rlast  <= (s_left == 8'd1); s_left <= s_left - 8'd1;
      end
    end
  end

  // ---------------- transaction monitor ----------------
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [31:0] out_pc_q[$];
  logic [31:0] out_instr_q[$];
  logic        out_fault_q[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
        $display("[%0t] AR    addr=0x%08h len=%0d", $time, araddr, arlen);
      end
      if (instr_valid && instr_ready) begin
        out_pc_q.push_back(instr_pc);
        out_instr_q.push_back(instruction);
        out_fault_q.push_back(instr_fault);
        $display("[%0t] INSTR pc=0x%08h data=0x%08h fault=%0b", $time, instr_pc, instruction, instr_fault);
      end
    end
  end

  function automatic logic [31:0] ar_at(input int i);
    if (i < ar_addr_q.size()) return ar_addr_q[i];
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] len_at(input int i);
    if (i < ar_len_q.size()) return {24'h0, ar_len_q[i]};
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] pc_at(input int i);
    if (i < out_pc_q.size()) return out_pc_q[i];
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] instr_at(input int i);
    if (i < out_instr_q.size()) return out_instr_q[i];
    return 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] fault_at(input int i);
    if (i < out_fault_q.size()) return {31'h0, out_fault_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- checking and helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    ar_addr_q.delete(); ar_len_q.delete();
    out_pc_q.delete(); out_instr_q.delete(); out_fault_q.delete();
  endtask

  task automatic quiesce();
    fetch_enable = 1'b0;
    instr_ready  = 1'b1;
    tick(16);
  endtask

  task automatic restart(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    clear_q();
    fetch_enable = 1'b1;
  endtask

  // Stops at the cycle in which the beat for addr is being accepted.
  task automatic wait_beat(input logic [31:0] addr, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rvalid && rready && (rdata == addr)) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'h0, seen}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
    check({pfx, "_arvalid"},     {31'h0, arvalid},     32'h0);
    check({pfx, "_rready"},      {31'h0, rready},      32'h0);
    check({pfx, "_araddr"},      araddr,               32'h0);
    check({pfx, "_arlen"},       {24'h0, arlen},       32'h0);
    check({pfx, "_instruction"}, instruction,          32'h0);
    check({pfx, "_instr_pc"},    instr_pc,             32'h0);
    check({pfx, "_instr_fault"}, {31'h0, instr_fault}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // ---- reset values and first-fetch latency ----
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    tick(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();                                   // cycle 1
    check("c1_arvalid", {31'h0, arvalid}, 32'h1);
    check("c1_araddr",  araddr, 32'h0);
    check("c1_arlen",   {24'h0, arlen}, 32'h3);
    check("c1_arburst", {30'h0, arburst}, 32'h1);
    check("c1_arsize",  {29'h0, arsize}, 32'h2);
    check("c1_arid",    {28'h0, arid}, 32'h0);
    tick();                                   // cycle 2
    check("c2_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("c2_rvalid",      {31'h0, rvalid}, 32'h1);
    tick();                                   // cycle 3
    check("c3_instr_valid", {31'h0, instr_valid}, 32'h1);
    check("c3_instr_pc",    instr_pc, 32'h0);
    tick(10);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc",    pc_at(i),    32'(i * 4));
      check("seq_instr", instr_at(i), 32'(i * 4));
    end
    quiesce();

    // ---- 4 KB boundary split ----
    restart(32'h0000_0FF8);
    tick(12);
    check("split_ar0",   ar_at(0),  32'h0000_0FF8);
    check("split_len0",  len_at(0), 32'h1);
    check("split_ar1",   ar_at(1),  32'h0000_1000);
    check("split_len1",  len_at(1), 32'h3);
    check("split_pc0",   pc_at(0),  32'h0000_0FF8);
    check("split_pc1",   pc_at(1),  32'h0000_0FFC);
    check("split_pc2",   pc_at(2),  32'h0000_1000);
    quiesce();

    // ---- back-pressure: reservation against a full FIFO ----
    instr_ready = 1'b0;
    restart(32'h100);
    tick(30);
    check("bp_ar_count",  32'(ar_addr_q.size()), 32'd2);
    check("bp_ar0",       ar_at(0), 32'h100);
    check("bp_ar1",       ar_at(1), 32'h110);
    check("bp_arvalid",   {31'h0, arvalid}, 32'h0);
    check("bp_head_pc",   instr_pc, 32'h100);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick(8);
    check("bp_pop1_ar_count", 32'(ar_addr_q.size()), 32'd2);
    instr_ready = 1'b1;
    tick(2);
    instr_ready = 1'b0;
    tick(5);
    check("bp_pop3_ar_count", 32'(ar_addr_q.size()), 32'd2);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ar_addr_q.size() >= 3) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("bp_third_burst", {31'h0, seen}, 32'h1);
    check("bp_ar2", ar_at(2), 32'h120);
    fetch_enable = 1'b0;
    tick(8);
    instr_ready = 1'b1;
    tick(16);
    check("bp_delivered", 32'(out_pc_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check("bp_pc", pc_at(i), 32'h100 + 32'(i * 4));
    end
    quiesce();

    // ---- redirect during beat 2 of a burst ----
    restart(32'h0);
    wait_beat(32'h4, "rd_wait_beat2");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    clear_q();
    check("rd_flush_valid", {31'h0, instr_valid}, 32'h0);
    check("rd_drain_rready", {31'h0, rready}, 32'h1);
    tick(15);
    check("rd_ar0", ar_at(0), 32'h200);
    for (int i = 0; i < 4; i++) begin
      check("rd_pc", pc_at(i), 32'h200 + 32'(i * 4));
    end
    quiesce();

    // ---- redirect while the address phase is stalled ----
    ar_ready_en = 1'b0;
    restart(32'h300);
    tick(2);
    check("hold_arvalid0", {31'h0, arvalid}, 32'h1);
    check("hold_araddr0",  araddr, 32'h300);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    redirect_valid = 1'b0;
    tick(3);
    check("hold_arvalid1", {31'h0, arvalid}, 32'h1);
    check("hold_araddr1",  araddr, 32'h300);
    ar_ready_en = 1'b1;
    tick(15);
    check("hold_ar0", ar_at(0), 32'h300);
    check("hold_ar1", ar_at(1), 32'h400);
    check("hold_pc0", pc_at(0), 32'h400);
    quiesce();

    // ---- bus fault tagging and halt ----
    fault_en   = 1'b1;
    fault_addr = 32'h44;
    restart(32'h40);
    tick(20);
    check("flt_ar_count", 32'(ar_addr_q.size()), 32'd1);
    check("flt_arvalid",  {31'h0, arvalid}, 32'h0);
    check("flt_delivered", 32'(out_pc_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("flt_pc",    pc_at(i),    32'h40 + 32'(i * 4));
      check("flt_fault", fault_at(i), (i == 1) ? 32'h1 : 32'h0);
    end
    fault_en = 1'b0;
    restart(32'h80);
    tick(12);
    check("flt_resume_ar", ar_at(0), 32'h80);
    check("flt_resume_pc", pc_at(0), 32'h80);
    quiesce();

    // ---- reset in the middle of a burst ----
    restart(32'h500);
    wait_beat(32'h504, "mrst_wait_beat");
    reset = 1'b1;
    tick();
    check_reset_outputs("mrst");
    reset = 1'b0;
    clear_q();
    tick(10);
    check("mrst_ar0",  ar_at(0), 32'h0);
    check("mrst_pc0",  pc_at(0), 32'h0);
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Parametrised successor to the core's single-shot instruction fetch path.
- Autonomously issues AXI4 INCR read bursts to the ICCM from a sequential fetch PC and buffers returned instructions in a prefetch FIFO.
- Presents the buffered instructions to the control unit over a valid/ready interface.
- Supports branch redirect with flush, in-flight burst drain, 4 KB boundary splitting and per-instruction bus-fault tagging.

Parameters:
- ADDR_W, 32, fetch/AXI address width.
- FIFO_DEPTH, 8, prefetch entries; power of 2, >= BURST_LEN.
- BURST_LEN, 4, maximum beats per burst, 1..16.
- AXI_ID, 0, constant ARID value.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous active-high reset.
- fetch_enable  in  1  permits issuing new bursts.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch PC; bits[1:0] ignored (forced 0).
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  consumer accepts head.
- instruction  out  32  head instruction.
- instr_pc  out  ADDR_W  PC of head instruction.
- instr_fault  out  1  head beat returned RRESP != OKAY.
- m_axi_araddr  out  ADDR_W  burst start address.
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arid  out  4  AXI_ID.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant 3'b010 (4 bytes).
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address accepted.
- m_axi_rdata  in  32  read data.
- m_axi_rid  in  4  ignored.
- m_axi_rresp  in  2  response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  beat valid.
- m_axi_rready  out  1  beat accept.

Behaviour:
- Reset values:
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE; halted=0.
  - Outputs: instr_valid=0, m_axi_arvalid=0, m_axi_rready=0, m_axi_araddr=0, m_axi_arlen=0, instruction=0, instr_pc=0, instr_fault=0.
- FSM states: IDLE, REQ, DATA, DRAIN.
- IDLE -> REQ when all of: fetch_enable=1, halted=0, no redirect this cycle, free_slots >= beats.
  - beats = min(BURST_LEN, (4096 - fetch_pc[11:0]) >> 2). Bursts never cross a 4 KB boundary.
  - free_slots = FIFO_DEPTH - count, counted including the pop in the same cycle.
  - araddr/arlen are registered on entry to REQ; arvalid=1 the following cycle.
- REQ:
  - arvalid, araddr and arlen are held stable until arready.
  - On arready: -> DATA, or -> DRAIN if a flush is pending.
- DATA:
  - rready=1 (space is guaranteed by reservation).
  - Each beat pushes {pc, rdata, rresp!=0}; fetch_pc += 4.
  - On rlast -> IDLE.
  - If any beat's rresp != 2'b00, halted=1. Remaining beats of that burst are still stored. No new bursts issue until redirect.
- DRAIN:
  - rready=1; beats are discarded and fetch_pc is not advanced.
  - On rlast -> IDLE, with fetch_pc = latched redirect target.
- Redirect (any state):
  - FIFO is flushed the same cycle; instr_valid=0 the next cycle.
  - halted is cleared; target is latched.
  - In IDLE: fetch_pc=target directly.
  - In REQ: arvalid is not dropped; -> DRAIN after arready.
  - In DATA: -> DRAIN.
  - A redirect during DRAIN overwrites the latched target.
- Simultaneous redirect and instr_valid&&instr_ready: the handshake completes (consumer owns that instruction), then the flush applies.
- Output latency: a beat accepted in cycle N gives instr_valid=1 in cycle N+1 (registered FIFO head).
  - Minimum to first instruction after reset release with zero-wait slave: arvalid in cycle 1, rvalid in cycle 2, instr_valid in cycle 3.
- fetch_enable=0: the current burst completes and no new burst issues. Buffered instructions remain deliverable.
- FIFO boundaries:
  - Push on full is impossible by construction and is covered by an assertion.
  - Pop on empty is ignored.
  - Pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits.
- fetch_pc wraps modulo 2^ADDR_W.
- Reset mid-burst: all state is cleared immediately. The slave is reset on the same reset.

Decomposition:
- Package ipfu_pkg:
  - AXI constants BURST_INCR, SIZE_4B, RESP_OKAY.
  - State enum ipfu_state_t {IDLE, REQ, DATA, DRAIN}.
  - Entry struct ipfu_entry_t {pc, instr, fault}.
- Sub-module prefetch_fifo:
  - Parametrised synchronous FIFO of ipfu_entry_t.
  - Provides flush, count, push and pop.

Test Plan:
- Reset, fetch_enable=1, zero-wait slave returning data=addr -> arvalid in cycle 1 with araddr=0, arlen=3; instructions 0x0,0x4,0x8,0xC appear in order with matching instr_pc; first instr_valid in cycle 3.
- redirect_pc=0x0000_0FF8 -> burst araddr=0xFF8, arlen=1; next burst araddr=0x1000, arlen=3 (4 KB split).
- instr_ready=0 with FIFO_DEPTH=8 -> exactly two bursts issue, FIFO holds 8 entries, no third arvalid; one pop frees 1 slot but no burst issues until 4 slots are free.
- Redirect to 0x200 during beat 2 of a 4-beat burst -> beats 3-4 are drained with rready=1 and never appear; the next instr_pc is 0x200; arvalid was held until arready.
- rresp=2'b10 on beat 2 of the burst at 0x40 -> instr_fault=1 only for pc 0x44; no further arvalid until redirect, after which fetching resumes.
- Reset asserted mid-DATA -> all outputs at reset values the next cycle; fetching restarts at RESET_PC.
